// File: rtl/contador_arbitro_pkg.sv
// Shared types, constants and the round-robin pick helper for the
// arbitrated up/down counter and any other block that arbitrates a resource.
package contador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        APPLY = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [7:0] INIT_DEFAULT = 8'h6A;

    // The pick helper works on a fixed 8-wide request vector; callers pad.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    // First set bit of req_v scanning upward from ptr, modulo n.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req_v,
        input logic [IDX_W-1:0]   ptr,
        input int                 n
    );
        logic [IDX_W-1:0] win_v;
        logic [IDX_W-1:0] idx_v;
        logic             found_v;
        win_v   = '0;
        found_v = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx_v = IDX_W'((int'(ptr) + i) % n);
            if ((i < n) && !found_v && req_v[idx_v]) begin
                win_v   = idx_v;
                found_v = 1'b1;
            end else begin
                found_v = found_v;
            end
        end
        return win_v;
    endfunction

endpackage

// File: rtl/contador_arbitro_if.sv
// Bus between the requesting agents and the shared counter.
interface contador_arbitro_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] dir;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] ack;
    logic [WIDTH-1:0] saida;
    logic             limite;
    logic             ocupado;

    modport master (
        output req, dir,
        input  gnt, ack, saida, limite, ocupado
    );

    modport slave (
        input  req, dir,
        output gnt, ack, saida, limite, ocupado
    );
endinterface

// File: rtl/contador_arbitro_rr.sv
// Combinational round-robin picker: lowest-index request at or above ptr,
// wrapping around. Reusable in front of any shared resource.
module rr_arbitro
    import contador_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    winner,
    output logic             valid
);

    // Widen to the helper's fixed width, pick, and narrow back.
    always_comb begin
        winner = PW'(rr_pick(MAX_REQ'(req), IDX_W'(ptr), N_REQ));
        valid  = |req;
    end

endmodule

// File: rtl/contador_arbitro.sv
// Shared up/down counter behind a round-robin arbiter. One operation per
// grant: IDLE picks a winner, GRANT precomputes the result, APPLY commits
// it and pulses ack (and limite when the bound was hit).
module contador_arbitro
    import contador_pkg::*;
#(
    parameter int               N_REQ    = 4,
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INIT     = WIDTH'(INIT_DEFAULT),
    parameter bit               SATURATE = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    contador_arbitro_if.slave bus
);

    localparam int               PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW-1:0]    LAST_IDX = PW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONEHOT0  = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [PW-1:0]    rr_ptr_r;
    logic [PW-1:0]    win_r;
    logic             op_dir_r;
    logic [WIDTH-1:0] next_val_r;
    logic             next_lim_r;
    logic [N_REQ-1:0] gnt_r;
    logic [N_REQ-1:0] ack_r;
    logic [WIDTH-1:0] saida_r;
    logic             limite_r;
    logic             ocupado_r;

    logic [N_REQ-1:0] cand_s;
    logic [PW-1:0]    win_s;
    logic             win_valid_s;
    logic [WIDTH-1:0] calc_val_s;
    logic             calc_lim_s;

    // A requester acked this cycle still holds a stale req; keep it out.
    assign cand_s = bus.req & ~ack_r;

    rr_arbitro #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr (
        .req    (cand_s),
        .ptr    (rr_ptr_r),
        .winner (win_s),
        .valid  (win_valid_s)
    );

    // Result of the latched operation, wrapping or clamping at the bounds.
    always_comb begin
        calc_val_s = saida_r;
        calc_lim_s = 1'b0;
        if (op_dir_r == DIR_UP) begin
            if (saida_r == MAX_VAL) begin
                calc_lim_s = 1'b1;
                if (SATURATE) begin
                    calc_val_s = saida_r;
                end else begin
                    calc_val_s = MIN_VAL;
                end
            end else begin
                calc_val_s = saida_r + ONE_VAL;
            end
        end else begin
            if (saida_r == MIN_VAL) begin
                calc_lim_s = 1'b1;
                if (SATURATE) begin
                    calc_val_s = saida_r;
                end else begin
                    calc_val_s = MAX_VAL;
                end
            end else begin
                calc_val_s = saida_r - ONE_VAL;
            end
        end
    end

    // Arbitration FSM and counter register; every output is registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            rr_ptr_r   <= '0;
            win_r      <= '0;
            op_dir_r   <= DIR_DOWN;
            next_val_r <= INIT;
            next_lim_r <= 1'b0;
            gnt_r      <= '0;
            ack_r      <= '0;
            saida_r    <= INIT;
            limite_r   <= 1'b0;
            ocupado_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack_r    <= '0;
                    limite_r <= 1'b0;
                    if (win_valid_s) begin
                        gnt_r     <= ONEHOT0 << win_s;
                        win_r     <= win_s;
                        op_dir_r  <= bus.dir[win_s];
                        ocupado_r <= 1'b1;
                        state_r   <= GRANT;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                GRANT: begin
                    next_val_r <= calc_val_s;
                    next_lim_r <= calc_lim_s;
                    state_r    <= APPLY;
                end
                APPLY: begin
                    saida_r   <= next_val_r;
                    limite_r  <= next_lim_r;
                    ack_r     <= ONEHOT0 << win_r;
                    gnt_r     <= '0;
                    rr_ptr_r  <= (win_r == LAST_IDX) ? '0 : (win_r + PW'(1));
                    ocupado_r <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    gnt_r     <= '0;
                    ack_r     <= '0;
                    limite_r  <= 1'b0;
                    ocupado_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.ack     = ack_r;
    assign bus.saida   = saida_r;
    assign bus.limite  = limite_r;
    assign bus.ocupado = ocupado_r;

endmodule

// File: tb/tb_contador_arbitro.sv
// Scoreboard bench: one wrapping and one saturating counter share the same
// requesters. The driver predicts service order and results per batch and
// queues them; the monitor pops and compares on every ack.
module tb_contador_arbitro;
    import contador_pkg::*;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MAXV = 255;
    localparam int INIT = 106;  // 8'h6A

    typedef struct {
        int idx;
        int val_w;
        int lim_w;
        int val_s;
        int lim_s;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_tb;
    logic [N-1:0] dir_tb;
    logic [N-1:0] drop_next;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    int model_w, model_s, model_ptr;

    contador_arbitro_if #(.N_REQ(N), .WIDTH(W)) if_w ();
    contador_arbitro_if #(.N_REQ(N), .WIDTH(W)) if_s ();

    assign if_w.req = req_tb;
    assign if_w.dir = dir_tb;
    assign if_s.req = req_tb;
    assign if_s.dir = dir_tb;

    contador_arbitro #(.N_REQ(N), .WIDTH(W), .INIT(8'h6A), .SATURATE(1'b0)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_w)
    );

    contador_arbitro #(.N_REQ(N), .WIDTH(W), .INIT(8'h6A), .SATURATE(1'b1)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic logic bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // Counter rule: +/-1, and at a bound either wrap or stay, flagging limite.
    task automatic predict(input int cur, input logic up, input logic sat,
                           output int nv, output int lim);
        if (up && cur == MAXV) begin
            lim = 1;
            nv  = sat ? cur : 0;
        end else if (!up && cur == 0) begin
            lim = 1;
            nv  = sat ? cur : MAXV;
        end else begin
            lim = 0;
            nv  = up ? cur + 1 : cur - 1;
        end
    endtask

    // One clock; then behave like well-mannered requesters.
    task automatic step();
        logic [N-1:0] early;
        @(posedge clk);
        #1;
        req_tb    = req_tb & ~drop_next;
        drop_next = if_w.ack;
        early     = N'($urandom) & N'($urandom);
        dir_tb    = dir_tb ^ (if_w.gnt & N'($urandom));
        req_tb    = req_tb & ~(if_w.gnt & early);
    endtask

    // Raise a set of requests together; predict the order they get served.
    task automatic run_batch(input logic [N-1:0] mask, input logic [N-1:0] dirs);
        logic [N-1:0] pend;
        int   w;
        int   guard;
        exp_t e;
        dir_tb = (dir_tb & ~mask) | (dirs & mask);
        req_tb = req_tb | mask;
        pend   = mask;
        while (pend != '0) begin
            w = model_ptr;
            while (!bit_at(pend, w)) w = (w + 1) % N;
            e.idx = w;
            predict(model_w, bit_at(dirs, w), 1'b0, e.val_w, e.lim_w);
            predict(model_s, bit_at(dirs, w), 1'b1, e.val_s, e.lim_s);
            model_w = e.val_w;
            model_s = e.val_s;
            exp_q.push_back(e);
            pend      = pend & ~(N'(1) << w);
            model_ptr = (w + 1) % N;
        end
        guard = 0;
        while ((req_tb != '0 || exp_q.size() != 0) && guard < 100) begin
            step();
            guard++;
        end
        chk("batch_done_in_time", 32'(guard < 100), 32'(1));
        step();
        step();
    endtask

    int   mon_cur_w, mon_cur_s, mon_age;
    logic [N-1:0] mon_prev_gnt;
    exp_t mon_e;

    // Monitor: grant order, latency, results on ack, and quiet outputs otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            mon_cur_w    = INIT;
            mon_cur_s    = INIT;
            mon_prev_gnt = '0;
            mon_age      = 0;
        end else begin
            mon_age++;
            if (if_w.gnt != '0 && if_w.gnt != mon_prev_gnt) begin
                mon_age = 0;
                if (exp_q.size() == 0) begin
                    chk("gnt_unexpected", 32'(if_w.gnt), 32'(0));
                end else begin
                    chk("gnt_order", 32'(if_w.gnt), 32'(N'(1) << exp_q[0].idx));
                end
                chk("gnt_sat_same", 32'(if_s.gnt), 32'(if_w.gnt));
            end
            mon_prev_gnt = if_w.gnt;
            chk("ocupado_w", 32'(if_w.ocupado), 32'(|if_w.gnt));
            chk("ocupado_s", 32'(if_s.ocupado), 32'(|if_s.gnt));
            chk("gnt_ack_overlap", 32'(if_w.gnt & if_w.ack), 32'(0));
            if (if_w.ack != '0 || if_s.ack != '0) begin
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", 32'(if_w.ack | if_s.ack), 32'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_w", 32'(if_w.ack), 32'(N'(1) << mon_e.idx));
                    chk("ack_s", 32'(if_s.ack), 32'(N'(1) << mon_e.idx));
                    chk("saida_w", 32'(if_w.saida), 32'(mon_e.val_w));
                    chk("limite_w", 32'(if_w.limite), 32'(mon_e.lim_w));
                    chk("saida_s", 32'(if_s.saida), 32'(mon_e.val_s));
                    chk("limite_s", 32'(if_s.limite), 32'(mon_e.lim_s));
                    chk("ack_latency", 32'(mon_age), 32'(2));
                    mon_cur_w = mon_e.val_w;
                    mon_cur_s = mon_e.val_s;
                end
            end else begin
                chk("hold_w", 32'(if_w.saida), 32'(mon_cur_w));
                chk("hold_s", 32'(if_s.saida), 32'(mon_cur_s));
                chk("limite_idle_w", 32'(if_w.limite), 32'(0));
                chk("limite_idle_s", 32'(if_s.limite), 32'(0));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_tb    = '0;
        dir_tb    = '0;
        drop_next = '0;
        model_w   = INIT;
        model_s   = INIT;
        model_ptr = 0;

        // Reset state, then hold after release.
        step();
        step();
        chk("rst_saida_w", 32'(if_w.saida), 32'(8'h6A));
        chk("rst_saida_s", 32'(if_s.saida), 32'(8'h6A));
        chk("rst_gnt", 32'(if_w.gnt), 32'(0));
        chk("rst_ack", 32'(if_w.ack), 32'(0));
        chk("rst_ocupado", 32'(if_w.ocupado), 32'(0));
        chk("rst_limite", 32'(if_w.limite), 32'(0));
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_saida", 32'(if_w.saida), 32'(8'h6A));
        chk("post_rst_gnt", 32'(if_w.gnt), 32'(0));

        // Single increment from requester 0.
        run_batch(4'b0001, 4'b0001);
        chk("single_inc", 32'(if_w.saida), 32'(8'h6B));

        // All four at once with alternating directions.
        run_batch(4'b1111, 4'b0101);

        // Random subsets and directions.
        repeat (40) begin
            run_batch(N'($urandom_range(1, 15)), N'($urandom));
        end

        // Climb through the top bound, then descend through the bottom one.
        repeat (70) run_batch(4'b1111, 4'b1111);
        chk("sat_top", 32'(if_s.saida), 32'(8'hFF));
        repeat (70) run_batch(4'b1111, 4'b0000);
        chk("sat_bottom", 32'(if_s.saida), 32'(8'h00));

        // Move the pointer to 2, then reset while requester 2 is granted.
        run_batch(4'b0010, 4'b0001);
        req_tb = 4'b0100;
        dir_tb = 4'b0100;
        step();
        chk("gnt_before_reset", 32'(if_w.gnt), 32'(4'b0100));
        rst_n     = 1'b0;
        req_tb    = '0;
        drop_next = '0;
        step();
        chk("midrst_gnt", 32'(if_w.gnt), 32'(0));
        chk("midrst_ack", 32'(if_w.ack), 32'(0));
        chk("midrst_saida_w", 32'(if_w.saida), 32'(8'h6A));
        chk("midrst_saida_s", 32'(if_s.saida), 32'(8'h6A));
        chk("midrst_ocupado", 32'(if_w.ocupado), 32'(0));
        rst_n     = 1'b1;
        model_w   = INIT;
        model_s   = INIT;
        model_ptr = 0;
        step();
        chk("midrst_no_ack", 32'(if_w.ack), 32'(0));
        run_batch(4'b1111, 4'b1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
